// File: rtl/test_harness_pkg.sv
// Shared types, constants and helpers for the chip-level test harness.
package test_harness_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    PASS  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  localparam logic [7:0] PASS_CHAR = 8'h50;  // 'P'
  localparam logic [7:0] FAIL_CHAR = 8'h46;  // 'F'

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/harness_uart_tx.sv
// One-byte 8N1 UART transmitter, LSB first, BAUD_DIV clocks per bit.
module harness_uart_tx #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [BW-1:0] baud_q;
  logic [3:0]    bits_q;
  logic [8:0]    shift_q;

  // Frame sequencer: start bit is driven on acceptance, then data and stop bits shift out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_q  <= '0;
      bits_q  <= '0;
      shift_q <= '1;
      busy    <= 1'b0;
      txd     <= 1'b1;
    end else if (clr) begin
      baud_q  <= '0;
      bits_q  <= '0;
      shift_q <= '1;
      busy    <= 1'b0;
      txd     <= 1'b1;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        txd     <= 1'b0;
        shift_q <= {1'b1, data};
        bits_q  <= 4'd9;
        baud_q  <= BAUD_LAST;
      end
    end else if (baud_q != '0) begin
      baud_q <= baud_q - BW'(1);
    end else if (bits_q == 4'd0) begin
      busy <= 1'b0;
      txd  <= 1'b1;
    end else begin
      txd     <= shift_q[0];
      shift_q <= {1'b1, shift_q[8:1]};
      bits_q  <= bits_q - 4'd1;
      baud_q  <= BAUD_LAST;
    end
  end

endmodule

// File: rtl/test_harness.sv
// Chip-level test harness: memory/LFSR self-test sequencer with UART result byte.
//
// state | meaning
// IDLE  | held while any sequencer reset request is active; LFSR preloaded
// WRITE | fill memory with the LFSR sequence, one word per clock
// READ  | read back words; compare each one cycle after its read issues
// CHECK | decide pass/fail from mismatch and diff-clock fault flags
// PASS  | terminal; io_success set, 'P' sent on UART
// FAIL  | terminal; 'F' sent on UART
module test_harness
  import test_harness_pkg::*;
#(
  parameter int          N_WORDS   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          BAUD_DIV  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic io_clkrxvip,
  input  logic io_clkrxvin,
  input  logic io_core_reset,
  input  logic io_dsp_reset,
  input  logic io_adcclkrst,
  input  logic io_ua_clock,
  input  logic io_ua_reset,
  input  logic io_ua_rxd,
  output logic io_ua_int,
  output logic io_ua_txd,
  input  logic io_adcextclk,
  inout  wire  io_adcbias,
  inout  wire  io_ADCINP,
  inout  wire  io_ADCINM,
  inout  wire  io_ADCCLKP,
  inout  wire  io_ADCCLKM,
  inout  wire  io_adcvddhadc,
  inout  wire  io_adcvddadc,
  inout  wire  io_adcvss,
  output logic io_success
);

  localparam int AW = (N_WORDS > 2) ? $clog2(N_WORDS) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(N_WORDS);

  // Analog pads are stubs only.
  assign io_adcbias    = 1'bz;
  assign io_ADCINP     = 1'bz;
  assign io_ADCINM     = 1'bz;
  assign io_ADCCLKP    = 1'bz;
  assign io_ADCCLKM    = 1'bz;
  assign io_adcvddhadc = 1'bz;
  assign io_adcvddadc  = 1'bz;
  assign io_adcvss     = 1'bz;

  logic unused_pins;
  assign unused_pins = &{1'b0, io_ua_clock, io_adcextclk, io_adcbias, io_ADCINP, io_ADCINM,
                         io_ADCCLKP, io_ADCCLKM, io_adcvddhadc, io_adcvddadc, io_adcvss};

  logic [2:0] req_s1, req_s2;
  logic       ua_s1, ua_s2;
  logic       rx_s1, rx_s2, rx_s3;
  logic       seq_rst, uart_rst;

  // Request synchronizers come out of reset asserted; rxd synchronizer comes out low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_s1 <= '1;
      req_s2 <= '1;
      ua_s1  <= 1'b1;
      ua_s2  <= 1'b1;
      rx_s1  <= 1'b0;
      rx_s2  <= 1'b0;
      rx_s3  <= 1'b0;
    end else begin
      req_s1 <= {io_core_reset, io_dsp_reset, io_adcclkrst};
      req_s2 <= req_s1;
      ua_s1  <= io_ua_reset;
      ua_s2  <= ua_s1;
      rx_s1  <= io_ua_rxd;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
    end
  end

  assign seq_rst  = |req_s2;
  assign uart_rst = ua_s2;

  // Sticky receive-activity flag on a synchronized falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) io_ua_int <= 1'b0;
    else        io_ua_int <= io_ua_int | (rx_s3 & ~rx_s2);
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   rd_data;
  logic          mismatch_q, fault_q, success_q, term_entry_q;
  logic          fault_now;
  logic          mem_we, cmp_en, uart_start, uart_busy;
  logic [7:0]    uart_data;
  logic [15:0]   mem [N_WORDS];

  // A fault seen in the CHECK cycle itself still counts toward the verdict.
  assign fault_now = fault_q | (!seq_rst && (io_clkrxvip == io_clkrxvin));

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; any sequencer reset request wins.
  always_comb begin
    state_d = state_q;
    if (seq_rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WRITE;
        WRITE:   if (cnt_q == CNT_LAST) state_d = READ;
        READ:    if (cnt_q == CNT_END) state_d = CHECK;
        CHECK:   state_d = (mismatch_q || fault_now) ? FAIL : PASS;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs; the UART start is a single pulse on terminal-state entry.
  always_comb begin
    mem_we     = (state_q == WRITE);
    cmp_en     = (state_q == READ) && (cnt_q != '0);
    uart_start = term_entry_q && ((state_q == PASS) || (state_q == FAIL));
    uart_data  = (state_q == PASS) ? PASS_CHAR : FAIL_CHAR;
  end

  // Sequencer datapath: word counter, LFSR, verdict flags and registered success.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      mismatch_q   <= 1'b0;
      fault_q      <= 1'b0;
      success_q    <= 1'b0;
      term_entry_q <= 1'b0;
    end else if (seq_rst) begin
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      mismatch_q   <= 1'b0;
      fault_q      <= 1'b0;
      success_q    <= 1'b0;
      term_entry_q <= 1'b0;
    end else begin
      fault_q      <= fault_now;
      success_q    <= (state_q == PASS);
      term_entry_q <= (state_q == CHECK);
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          lfsr_q <= LFSR_SEED;
        end
        WRITE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            lfsr_q <= lfsr_next(lfsr_q);
          end
        end
        READ: begin
          if (cnt_q != CNT_END) cnt_q <= cnt_q + CW'(1);
          if (cmp_en) begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (rd_data != lfsr_q) mismatch_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Test memory with one-cycle synchronous read.
  always_ff @(posedge clock) begin
    if (mem_we) mem[cnt_q[AW-1:0]] <= lfsr_q;
    rd_data <= mem[cnt_q[AW-1:0]];
  end

  assign io_success = success_q;

  harness_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clock (clock),
    .reset (reset),
    .clr   (uart_rst),
    .start (uart_start),
    .data  (uart_data),
    .busy  (uart_busy),
    .txd   (io_ua_txd)
  );

endmodule

// File: tb/tb_test_harness.sv
// Directed self-checking bench for test_harness (N_WORDS=16, BAUD_DIV=16).
module tb_test_harness;
  import test_harness_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic vip = 1'b0, vin = 1'b1, diff_bad = 1'b0;
  logic core_rst = 1'b0, dsp_rst = 1'b0, adc_rst = 1'b0;
  logic ua_clock = 1'b0, ua_reset = 1'b0, rxd = 1'b0, adcextclk = 1'b0;
  logic ua_int, txd, success;
  wire  a_bias, a_inp, a_inm, a_clkp, a_clkm, a_vddh, a_vdd, a_vss;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [16];
  logic [15:0] flip_val;

  test_harness #(.N_WORDS(16), .LFSR_SEED(16'hACE1), .BAUD_DIV(16)) dut (
    .clock(clock), .reset(reset),
    .io_clkrxvip(vip), .io_clkrxvin(vin),
    .io_core_reset(core_rst), .io_dsp_reset(dsp_rst), .io_adcclkrst(adc_rst),
    .io_ua_clock(ua_clock), .io_ua_reset(ua_reset), .io_ua_rxd(rxd),
    .io_ua_int(ua_int), .io_ua_txd(txd), .io_adcextclk(adcextclk),
    .io_adcbias(a_bias), .io_ADCINP(a_inp), .io_ADCINM(a_inm),
    .io_ADCCLKP(a_clkp), .io_ADCCLKM(a_clkm), .io_adcvddhadc(a_vddh),
    .io_adcvddadc(a_vdd), .io_adcvss(a_vss),
    .io_success(success)
  );

  always #5 clock = ~clock;

  // Differential clock pair: complementary toggling unless a fault is requested.
  always @(negedge clock) begin
    if (diff_bad) begin
      vip = 1'b1;
      vin = 1'b1;
    end else begin
      vip = ~vip;
      vin = ~vip;
    end
  end

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t exp);
    logic [2:0] obs;
    obs = dut.state_q;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed state %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called one step after the edge where the start bit begins; samples mid-bit.
  task automatic check_frame(input string tag, input logic [7:0] b, input int nbits);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    tick(8);
    for (int j = 0; j < nbits; j++) begin
      check_bit($sformatf("%s_bit%0d", tag, j), txd, fr[j]);
      if (j < nbits - 1) tick(16);
    end
  endtask

  initial begin
    model[0] = 16'hACE1;
    for (int i = 1; i < 16; i++) model[i] = ref_lfsr(model[i-1]);

    // Reset state
    #12;
    check_bit("rst_success", success, 1'b0);
    check_bit("rst_txd", txd, 1'b1);
    check_bit("rst_int", ua_int, 1'b0);
    check_state("rst_state", IDLE);

    // Run 1: nominal pass
    @(posedge clock);
    #1 reset = 1'b1;
    tick(2);
    check_state("n_idle_e2", IDLE);
    tick(1);
    check_state("n_write_e3", WRITE);
    tick(16);
    check_state("n_read_e19", READ);
    tick(17);
    check_state("n_check_e36", CHECK);
    tick(1);
    check_state("n_pass_e37", PASS);
    check_bit("n_succ_e37", success, 1'b0);
    tick(1);
    check_bit("n_succ_e38", success, 1'b1);
    check_bit("n_start_e38", txd, 1'b0);
    check_frame("n_frame", PASS_CHAR, 10);
    tick(16);
    check_bit("n_idle_txd", txd, 1'b1);
    check_bit("n_succ_hold", success, 1'b1);
    check_bit("n_int_low", ua_int, 1'b0);

    // Run 2: diff-clock fault mid-WRITE, then async reset mid-frame
    reset = 1'b0;
    #3 reset = 1'b1;
    tick(3);
    check_state("f_write_e3", WRITE);
    tick(5);
    diff_bad = 1'b1;
    tick(1);
    diff_bad = 1'b0;
    tick(28);
    check_state("f_fail_e37", FAIL);
    tick(1);
    check_bit("f_succ_e38", success, 1'b0);
    check_bit("f_start_e38", txd, 1'b0);
    check_frame("f_frame", FAIL_CHAR, 6);
    #2 reset = 1'b0;
    #1;
    check_bit("ar_txd", txd, 1'b1);
    check_bit("ar_succ", success, 1'b0);
    check_state("ar_state", IDLE);

    // Run 3: core reset pulse during READ
    #1 reset = 1'b1;
    tick(3);
    check_state("c_write_e3", WRITE);
    tick(21);
    check_state("c_read_e24", READ);
    core_rst = 1'b1;
    tick(1);
    core_rst = 1'b0;
    tick(1);
    check_state("c_read_e26", READ);
    tick(1);
    check_state("c_idle_e27", IDLE);
    tick(1);
    check_state("c_write_e28", WRITE);
    tick(34);
    check_bit("c_succ_e62", success, 1'b0);
    tick(1);
    check_bit("c_succ_e63", success, 1'b1);
    check_frame("c_frame", PASS_CHAR, 2);

    // Run 4: rxd falling edge sets the sticky flag; seq reset leaves it set
    rxd = 1'b1;
    tick(4);
    check_bit("rx_rise_noint", ua_int, 1'b0);
    rxd = 1'b0;
    tick(2);
    check_bit("rx_int_k2", ua_int, 1'b0);
    tick(1);
    check_bit("rx_int_k3", ua_int, 1'b1);
    dsp_rst = 1'b1;
    tick(4);
    check_bit("rx_int_hold", ua_int, 1'b1);
    check_state("d_idle", IDLE);
    check_bit("d_succ_clr", success, 1'b0);
    dsp_rst = 1'b0;

    // Run 5: corrupted read-back word forces FAIL
    reset = 1'b0;
    #3 reset = 1'b1;
    tick(3);
    check_bit("m_int_clr", ua_int, 1'b0);
    check_state("m_write_e3", WRITE);
    tick(20);
    flip_val = model[3] ^ 16'h0008;
    force dut.rd_data = flip_val;
    tick(1);
    release dut.rd_data;
    tick(13);
    check_state("m_fail_e37", FAIL);
    tick(1);
    check_bit("m_succ_e38", success, 1'b0);
    check_bit("m_start_e38", txd, 1'b0);
    check_frame("m_frame", FAIL_CHAR, 10);
    tick(16);
    check_bit("m_succ_end", success, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_harness.md
# test_harness

Top-level simulation harness for the chip-level test driver. It wraps a self-checking memory/LFSR test sequencer, a one-byte UART result reporter, reset synchronizers and analog pad stubs. It raises `io_success` once the built-in test passes, and the driver ends simulation on that signal.

## Interface
Parameters:
- `N_WORDS`, 16: words written and read back (power of 2, 2..256).
- `LFSR_SEED`, 16'hACE1: nonzero LFSR seed.
- `BAUD_DIV`, 16: clocks per UART bit (≥2).

Ports:
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low global reset.
- `io_clkrxvip`, `io_clkrxvin` in 1 each: differential core-clock pair, sampled as data on `clock`.
- `io_core_reset`, `io_dsp_reset`, `io_adcclkrst` in 1 each: active-high sequencer reset requests.
- `io_ua_clock` in 1: reserved, ignored; tie 0.
- `io_ua_reset` in 1: active-high UART reset request.
- `io_ua_rxd` in 1: UART receive line.
- `io_ua_int` out 1: sticky flag for a falling edge on rxd.
- `io_ua_txd` out 1: UART transmit line, idles high.
- `io_adcextclk` in 1: ignored.
- `io_adcbias`, `io_ADCINP`, `io_ADCINM`, `io_ADCCLKP`, `io_ADCCLKM`, `io_adcvddhadc`, `io_adcvddadc`, `io_adcvss` inout 1 each: analog stubs, never driven (z).
- `io_success` out 1: test passed; held until reset.

## Operation
- Active-high request inputs pass through 2-flop synchronizers that reset to 1.
- `seq_rst` = OR of synchronized core/dsp/adcclk requests. `uart_rst` = synchronized `io_ua_reset`.
- rxd synchronizer resets to 0. `io_ua_int` sets on a synchronized 1→0 transition and clears only on `reset`.
- Diff fault: `io_clkrxvip == io_clkrxvin` sampled in any cycle while `seq_rst` is low. This sets sticky `fault`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. `next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- Memory: `N_WORDS`×16, synchronous read, 1-cycle latency.
- FSM states:
  - IDLE → WRITE when `seq_rst` is low. Entry loads LFSR = seed.
  - WRITE: mem[addr] = lfsr, lfsr advances, addr++. After N_WORDS writes: → READ, reload seed, addr = 0.
  - READ: issue reads addr 0..N-1. Compare each returned word against the regenerated LFSR one cycle later. Any mismatch sets `mismatch`.
  - CHECK: one cycle after the last compare. → PASS if !mismatch && !fault, else → FAIL.
  - PASS/FAIL: terminal. Entering either starts a UART frame: 0x50 ('P') or 0x46 ('F').
- `seq_rst` high in any state returns the FSM to IDLE next cycle. It clears `mismatch`, `fault` and `io_success`.
- UART TX: 8N1, LSB first, each bit BAUD_DIV clocks. Start pulse ignored if busy. `uart_rst` aborts a frame and forces txd = 1.

## Timing
- Reset values: `io_success`=0, `io_ua_txd`=1, `io_ua_int`=0, FSM=IDLE.
- `seq_rst` falls 2 clocks after requests deassert.
- WRITE spans N_WORDS cycles and READ spans N_WORDS+1 cycles. CHECK is 1 cycle.
- `io_success` (registered) rises exactly 2·N_WORDS+3 clocks after the IDLE→WRITE edge: 35 for N=16.
- UART frame starts the cycle after PASS/FAIL entry and lasts 10·BAUD_DIV clocks (160).
- A fault arriving on the same cycle as CHECK counts as a fault.

## Structure
- Package `test_harness_pkg`: FSM state enum (IDLE, WRITE, READ, CHECK, PASS, FAIL), `PASS_CHAR`/`FAIL_CHAR` constants, `lfsr_next` function.
- Sub-module `harness_uart_tx` (BAUD_DIV parameter; start, data[7:0], busy, txd).
- Memory and synchronizers are inline.

## Test plan
- Nominal: vip = ~vin toggling, all requests released → `io_success` rises 35 clocks after WRITE entry. txd sends 0x50: start 0, bits 0,0,0,0,1,0,1,0, stop 1.
- Diff fault: hold vip = vin = 1 for one cycle mid-WRITE → `io_success` stays 0, txd sends 0x46.
- Mid-run `io_core_reset` pulse during READ → FSM returns to IDLE. After release, success arrives a full 35 clocks after re-entering WRITE.
- Async `reset` low mid-UART frame → txd = 1 immediately, `io_success` = 0.
- rxd 0→1→0 → `io_ua_int` sets 3 clocks after the falling edge and stays set. rxd tied 0 from reset → `io_ua_int` stays 0.
- Force a memory bit flip (bench force) → FAIL, `io_success` = 0.
